// File: rtl/axi_req_arbiter.sv
// ---------------------------------------------------------------------------
// axi_req_arbiter
//
// Shares the single-outstanding request/response port of the AXI master
// driver between NUM_REQ requesters. One requester at a time owns the driver:
// the owner is picked round-robin in IDLE, and its request is forwarded in
// ISSUE. The grant is held through WAIT until the driver's response pulse
// comes back. The response is routed to the owner only.
//
// Optional feature (compile-time macro AXI_ARB_TIMEOUT_EN):
//   A WAIT watchdog. After TIMEOUT_CYCLES cycles in WAIT with no response,
//   the arbiter pulses s_resp_err[owner] and moves to DRAIN. DRAIN swallows
//   the late response and then returns to IDLE. Without the macro there is
//   no counter and no DRAIN state, s_resp_err is always 0, and WAIT waits
//   indefinitely.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   s_req_valid     per-requester request valid
//   s_req_ready     per-requester accept (one-hot or zero)
//   s_req_is_write  per-requester request type (1 = write)
//   s_req_addr      flattened addresses, requester i at slice i
//   s_req_wdata     flattened write data
//   s_req_wstrb     flattened byte strobes
//   s_resp_valid    one-cycle response pulse to the owner
//   s_resp_data     response data, shared by all requesters
//   s_resp_err      one-cycle timeout-error pulse to the owner
//   m_req_*         request forwarded to the AXI driver
//   m_resp_valid    driver response pulse
//   m_resp_data     driver response data
//   grant_id        current / last owner index
//   busy            high whenever the state is not IDLE
// ---------------------------------------------------------------------------
module axi_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int STRB_WIDTH    = AXI_DATA_WIDTH / 8,
  localparam int ID_WIDTH      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  s_req_valid,
  output logic [NUM_REQ-1:0]                  s_req_ready,
  input  logic [NUM_REQ-1:0]                  s_req_is_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   s_req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]       s_req_wstrb,
  output logic [NUM_REQ-1:0]                  s_resp_valid,
  output logic [AXI_DATA_WIDTH-1:0]           s_resp_data,
  output logic [NUM_REQ-1:0]                  s_resp_err,
  output logic                                m_req_valid,
  input  logic                                m_req_ready,
  output logic                                m_req_is_write,
  output logic [AXI_ADDR_WIDTH-1:0]           m_req_addr,
  output logic [AXI_DATA_WIDTH-1:0]           m_req_wdata,
  output logic [STRB_WIDTH-1:0]               m_req_wstrb,
  input  logic                                m_resp_valid,
  input  logic [AXI_DATA_WIDTH-1:0]           m_resp_data,
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic                                busy
);

  // Elaboration-time sanity check on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("axi_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
`ifdef AXI_ARB_TIMEOUT_EN
    WAIT  = 2'd2,
    DRAIN = 2'd3
`else
    WAIT  = 2'd2
`endif
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic [ID_WIDTH-1:0] arb_pick;
  logic                arb_found;
  int                  arb_idx;
  logic [ID_WIDTH-1:0] owner_inc;
  logic                owner_valid;
  logic                resp_done;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 timeout_hit;
`endif

  // Round-robin pick: the first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = {ID_WIDTH{1'b0}};
    arb_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_REQ) begin
        arb_idx = arb_idx - NUM_REQ;
      end else begin
        arb_idx = arb_idx;
      end
      if (!arb_found && s_req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = ID_WIDTH'(arb_idx);
      end else begin
        arb_found = arb_found;
      end
    end
  end

  // Owner-relative helpers: wrapped successor and the owner's live valid.
  always_comb begin
    if (owner == ID_WIDTH'(NUM_REQ - 1)) begin
      owner_inc = {ID_WIDTH{1'b0}};
    end else begin
      owner_inc = owner + {{(ID_WIDTH-1){1'b0}}, 1'b1};
    end
    owner_valid = s_req_valid[owner];
  end

`ifdef AXI_ARB_TIMEOUT_EN
  // Terminal count only counts as a timeout when no response arrives on that
  // same cycle; a simultaneous response is treated as a normal completion.
  assign timeout_hit = (state == WAIT) && !m_resp_valid &&
                       (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign resp_done   = ((state == WAIT) || (state == DRAIN)) && m_resp_valid;
`else
  assign resp_done   = (state == WAIT) && m_resp_valid;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (arb_found) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        // A withdrawn request abandons the grant without touching rr_ptr.
        if (!owner_valid) begin
          next_state = IDLE;
        end else if (m_req_ready) begin
          next_state = WAIT;
        end else begin
          next_state = ISSUE;
        end
      end
      WAIT: begin
        if (m_resp_valid) begin
          next_state = IDLE;
`ifdef AXI_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          next_state = DRAIN;
`endif
        end else begin
          next_state = WAIT;
        end
      end
`ifdef AXI_ARB_TIMEOUT_EN
      DRAIN: begin
        if (m_resp_valid) begin
          next_state = IDLE;
        end else begin
          next_state = DRAIN;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Owner capture on arbitration and round-robin pointer advance on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= {ID_WIDTH{1'b0}};
      rr_ptr <= {ID_WIDTH{1'b0}};
    end else begin
      if ((state == IDLE) && arb_found) begin
        owner <= arb_pick;
      end else begin
        owner <= owner;
      end
      if (resp_done) begin
        rr_ptr <= owner_inc;
      end else begin
        rr_ptr <= rr_ptr;
      end
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  // WAIT watchdog: cleared on the ISSUE->WAIT handshake, counts WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= {CNT_WIDTH{1'b0}};
    end else if ((state == ISSUE) && owner_valid && m_req_ready) begin
      wait_cnt <= {CNT_WIDTH{1'b0}};
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt <= wait_cnt;
    end
  end
`endif

  // Output decode: forward the owner's request in ISSUE and route the
  // response to the owner in WAIT. Everything idles at zero otherwise.
  always_comb begin
    s_req_ready    = {NUM_REQ{1'b0}};
    s_resp_valid   = {NUM_REQ{1'b0}};
    s_resp_err     = {NUM_REQ{1'b0}};
    s_resp_data    = {AXI_DATA_WIDTH{1'b0}};
    m_req_valid    = 1'b0;
    m_req_is_write = 1'b0;
    m_req_addr     = {AXI_ADDR_WIDTH{1'b0}};
    m_req_wdata    = {AXI_DATA_WIDTH{1'b0}};
    m_req_wstrb    = {STRB_WIDTH{1'b0}};
    case (state)
      ISSUE: begin
        m_req_valid          = owner_valid;
        m_req_is_write       = s_req_is_write[owner];
        m_req_addr           = s_req_addr[int'(owner)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_req_wdata          = s_req_wdata[int'(owner)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        m_req_wstrb          = s_req_wstrb[int'(owner)*STRB_WIDTH +: STRB_WIDTH];
        s_req_ready[owner]   = m_req_ready;
      end
      WAIT: begin
        s_resp_valid[owner]  = m_resp_valid;
        s_resp_data          = m_resp_data;
`ifdef AXI_ARB_TIMEOUT_EN
        s_resp_err[owner]    = timeout_hit;
`endif
      end
      default: begin
        s_req_ready          = {NUM_REQ{1'b0}};
      end
    endcase
  end

  assign grant_id = owner;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_axi_req_arbiter.sv
module tb_axi_req_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      s_req_valid;
  logic [N-1:0]      s_req_ready;
  logic [N-1:0]      s_req_is_write;
  logic [N*AW-1:0]   s_req_addr;
  logic [N*DW-1:0]   s_req_wdata;
  logic [N*SW-1:0]   s_req_wstrb;
  logic [N-1:0]      s_resp_valid;
  logic [DW-1:0]     s_resp_data;
  logic [N-1:0]      s_resp_err;
  logic              m_req_valid;
  logic              m_req_ready;
  logic              m_req_is_write;
  logic [AW-1:0]     m_req_addr;
  logic [DW-1:0]     m_req_wdata;
  logic [SW-1:0]     m_req_wstrb;
  logic              m_resp_valid;
  logic [DW-1:0]     m_resp_data;
  logic [0:0]        grant_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: round-robin pointer and the requesters' payloads.
  int            rr;
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata[N];
  logic [SW-1:0] p_wstrb[N];
  logic          p_wr   [N];

  axi_req_arbiter #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_is_write(s_req_is_write), .s_req_addr(s_req_addr),
    .s_req_wdata(s_req_wdata), .s_req_wstrb(s_req_wstrb),
    .s_resp_valid(s_resp_valid), .s_resp_data(s_resp_data), .s_resp_err(s_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_is_write(m_req_is_write), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Spec rule: first pending requester at or after ptr, modulo N.
  function automatic int ref_pick(logic [N-1:0] mask, int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      s_req_addr[i*AW +: AW]  = p_addr[i];
      s_req_wdata[i*DW +: DW] = p_wdata[i];
      s_req_wstrb[i*SW +: SW] = p_wstrb[i];
      s_req_is_write[i]       = p_wr[i];
    end
  endtask

  task automatic rand_payload(int i);
    p_addr[i]  = $urandom();
    p_wdata[i] = {$urandom(), $urandom()};
    p_wstrb[i] = 8'($urandom());
    p_wr[i]    = 1'($urandom());
    pack();
  endtask

  task automatic do_reset();
    s_req_valid = '0;
    m_req_ready = 1'b0;
    m_resp_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_req_valid = 2'b11;
    m_req_ready = 1'b1;
    m_resp_valid = 1'b1;
    m_resp_data = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < N; i++) rand_payload(i);
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0h expected 0", grant_id); end
    checks++; if ({m_req_valid, s_req_ready, s_resp_valid, s_resp_err} !== 7'd0) begin
      errors++; $display("FAIL reset_valids: got %0h expected 0", {m_req_valid, s_req_ready, s_resp_valid, s_resp_err}); end
    checks++; if ({m_req_addr, m_req_wdata, m_req_wstrb, m_req_is_write, s_resp_data} !== '0) begin
      errors++; $display("FAIL reset_payload: got nonzero payload expected 0"); end
    s_req_valid = '0; m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    tick();
  endtask

  task automatic test_single_read();
    p_addr[1] = 32'h0000_1000; p_wr[1] = 1'b0; pack();
    s_req_valid = 2'b10;
    m_req_ready = 1'b1;
    tick();
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL single_grant: got %0h expected 1", grant_id); end
    checks++; if (m_req_valid !== 1'b1 || m_req_addr !== 32'h0000_1000 || m_req_is_write !== 1'b0) begin
      errors++; $display("FAIL single_fwd: got v=%0h a=%0h w=%0h expected v=1 a=1000 w=0", m_req_valid, m_req_addr, m_req_is_write); end
    checks++; if (s_req_ready !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", s_req_ready); end
    tick();
    s_req_valid = '0;
    m_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (s_resp_valid !== 2'b00 || s_req_ready !== 2'b00) begin
        errors++; $display("FAIL single_wait: got rv=%b rdy=%b expected 00/00", s_resp_valid, s_req_ready); end
      tick();
    end
    m_resp_valid = 1'b1;
    m_resp_data = 64'hDEADBEEF_CAFEF00D;
    #1;
    checks++; if (s_resp_valid !== 2'b10 || s_resp_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL single_resp: got %b/%h expected 10/deadbeefcafef00d", s_resp_valid, s_resp_data); end
    tick();
    m_resp_valid = 1'b0;
    checks++; if (s_resp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got rv=%b busy=%0h expected 00/0", s_resp_valid, busy); end
    rr = 0;
  endtask

  task automatic test_round_robin();
    int exp;
    logic [N-1:0] em;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    s_req_valid = 2'b11;
    m_req_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      exp = ref_pick(2'b11, rr);
      em = 2'b01 << exp;
      checks++; if (grant_id !== 1'(exp) || exp != t % N) begin
        errors++; $display("FAIL rr_grant: got %0d expected %0d (turn %0d)", grant_id, t % N, t); end
      checks++; if (s_req_ready !== em || m_req_addr !== p_addr[exp] || m_req_wdata !== p_wdata[exp]) begin
        errors++; $display("FAIL rr_fwd: got rdy=%b a=%h expected rdy=%b a=%h", s_req_ready, m_req_addr, em, p_addr[exp]); end
      tick();
      rand_payload(exp);
      repeat ($urandom_range(0, 3)) begin
        checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL rr_early: got %b expected 00", s_resp_valid); end
        tick();
      end
      d = {$urandom(), $urandom()};
      m_resp_valid = 1'b1; m_resp_data = d;
      #1;
      checks++; if (s_resp_valid !== em || s_resp_data !== d) begin
        errors++; $display("FAIL rr_resp: got %b/%h expected %b/%h", s_resp_valid, s_resp_data, em, d); end
      tick();
      m_resp_valid = 1'b0;
      rr = (exp + 1) % N;
    end
    s_req_valid = '0;
    m_req_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int exp;
    rand_payload(0);
    s_req_valid = 2'b01;
    m_req_ready = 1'b0;
    tick();
    exp = ref_pick(2'b01, rr);
    for (int c = 0; c < 10; c++) begin
      m_resp_valid = (c == 3);
      #1;
      checks++; if (m_req_valid !== 1'b1 || m_req_addr !== p_addr[exp] || m_req_wdata !== p_wdata[exp] ||
                    m_req_wstrb !== p_wstrb[exp] || s_req_ready !== 2'b00 || busy !== 1'b1 || s_resp_valid !== 2'b00) begin
        errors++; $display("FAIL bp_hold: got v=%0h a=%h rdy=%b rv=%b expected 1/%h/00/00", m_req_valid, m_req_addr, s_req_ready, s_resp_valid, p_addr[exp]); end
      tick();
    end
    m_resp_valid = 1'b0;
    m_req_ready = 1'b1;
    #1;
    checks++; if (s_req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready: got %b expected 01", s_req_ready); end
    tick();
    s_req_valid = '0; m_req_ready = 1'b0;
    m_resp_valid = 1'b1; m_resp_data = 64'h0BAD_F00D_0000_0001;
    #1;
    checks++; if (s_resp_valid !== 2'b01 || s_resp_data !== 64'h0BAD_F00D_0000_0001) begin
      errors++; $display("FAIL bp_resp: got %b/%h expected 01/0badf00d00000001", s_resp_valid, s_resp_data); end
    tick();
    m_resp_valid = 1'b0;
    rr = (exp + 1) % N;
  endtask

  task automatic test_withdrawal();
    do_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    s_req_valid = 2'b11;
    m_req_ready = 1'b0;
    tick();
    checks++; if (grant_id !== 1'(ref_pick(2'b11, rr))) begin errors++; $display("FAIL wd_first: got %0d expected %0d", grant_id, ref_pick(2'b11, rr)); end
    s_req_valid = 2'b10;
    #1;
    checks++; if (m_req_valid !== 1'b0 || s_req_ready !== 2'b00) begin
      errors++; $display("FAIL wd_drop: got v=%0h rdy=%b expected 0/00", m_req_valid, s_req_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got busy=%0h expected 0", busy); end
    tick();
    checks++; if (grant_id !== 1'(ref_pick(2'b10, rr)) || busy !== 1'b1) begin
      errors++; $display("FAIL wd_next: got %0d expected %0d", grant_id, ref_pick(2'b10, rr)); end
    s_req_valid = 2'b00;
    tick();
    s_req_valid = 2'b11;
    tick();
    checks++; if (grant_id !== 1'(ref_pick(2'b11, rr))) begin
      errors++; $display("FAIL wd_rr_kept: got %0d expected %0d", grant_id, ref_pick(2'b11, rr)); end
    m_req_ready = 1'b1;
    tick();
    s_req_valid = '0; m_req_ready = 1'b0;
    m_resp_valid = 1'b1;
    tick();
    m_resp_valid = 1'b0;
    rr = (ref_pick(2'b11, rr) + 1) % N;
  endtask

  task automatic test_reset_mid_wait();
    rand_payload(0);
    s_req_valid = 2'b01; m_req_ready = 1'b1;
    tick(); tick();
    s_req_valid = '0; m_req_ready = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmw_wait: got busy=%0h expected 1", busy); end
    #2 rst = 1'b1;
    m_resp_valid = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || s_resp_valid !== 2'b00 || m_req_valid !== 1'b0 || grant_id !== 1'b0) begin
      errors++; $display("FAIL rmw_async: got busy=%0h rv=%b v=%0h g=%0d expected 0/00/0/0", busy, s_resp_valid, m_req_valid, grant_id); end
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    tick();
    checks++; if (s_resp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL rmw_late: got rv=%b busy=%0h expected 00/0", s_resp_valid, busy); end
    m_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [N-1:0] em;
    logic [DW-1:0] d;
    int exp;
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) if (mask[i]) rand_payload(i);
      s_req_valid = mask;
      m_req_ready = 1'b0;
      tick();
      exp = ref_pick(mask, rr);
      em = 2'b01 << exp;
      checks++; if (grant_id !== 1'(exp) || busy !== 1'b1) begin
        errors++; $display("FAIL rnd_grant: got %0d expected %0d mask=%b", grant_id, exp, mask); end
      repeat ($urandom_range(0, 3)) begin
        checks++; if (m_req_addr !== p_addr[exp] || m_req_is_write !== p_wr[exp] || s_req_ready !== 2'b00) begin
          errors++; $display("FAIL rnd_stall: got a=%h rdy=%b expected a=%h rdy=00", m_req_addr, s_req_ready, p_addr[exp]); end
        tick();
      end
      if ($urandom_range(0, 3) == 0) begin
        s_req_valid = '0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_withdraw: got busy=%0h expected 0", busy); end
      end else begin
        m_req_ready = 1'b1;
        #1;
        checks++; if (s_req_ready !== em) begin errors++; $display("FAIL rnd_ready: got %b expected %b", s_req_ready, em); end
        tick();
        s_req_valid = '0; m_req_ready = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        d = {$urandom(), $urandom()};
        m_resp_valid = 1'b1; m_resp_data = d;
        #1;
        checks++; if (s_resp_valid !== em || s_resp_data !== d || s_resp_err !== 2'b00) begin
          errors++; $display("FAIL rnd_resp: got %b/%h err=%b expected %b/%h err=00", s_resp_valid, s_resp_data, s_resp_err, em, d); end
        tick();
        m_resp_valid = 1'b0;
        rr = (exp + 1) % N;
      end
    end
  endtask

`ifdef AXI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    rand_payload(0); rand_payload(1);
    s_req_valid = 2'b01; m_req_ready = 1'b1;
    tick(); tick();
    s_req_valid = '0; m_req_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      checks++; if (s_resp_err !== 2'b00) begin errors++; $display("FAIL to_early: got %b expected 00 at %0d", s_resp_err, c); end
      tick();
    end
    checks++; if (s_resp_err !== 2'b01 || s_resp_valid !== 2'b00) begin
      errors++; $display("FAIL to_pulse: got err=%b rv=%b expected 01/00", s_resp_err, s_resp_valid); end
    tick();
    checks++; if (s_resp_err !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL to_drain: got err=%b busy=%0h expected 00/1", s_resp_err, busy); end
    tick(); tick();
    m_resp_valid = 1'b1;
    #1;
    checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL to_discard: got %b expected 00", s_resp_valid); end
    tick();
    m_resp_valid = 1'b0;
    rr = 1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%0h expected 0", busy); end
    s_req_valid = 2'b11;
    tick();
    checks++; if (grant_id !== 1'(ref_pick(2'b11, rr))) begin
      errors++; $display("FAIL to_next: got %0d expected %0d", grant_id, ref_pick(2'b11, rr)); end
    m_req_ready = 1'b1;
    tick();
    s_req_valid = '0; m_req_ready = 1'b0;
    repeat (15) tick();
    m_resp_valid = 1'b1;
    #1;
    checks++; if (s_resp_valid !== 2'b10 || s_resp_err !== 2'b00) begin
      errors++; $display("FAIL to_terminal: got rv=%b err=%b expected 10/00", s_resp_valid, s_resp_err); end
    tick();
    m_resp_valid = 1'b0;
    rr = 0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    s_req_valid = '0; s_req_is_write = '0; s_req_addr = '0; s_req_wdata = '0; s_req_wstrb = '0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
    rr = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_withdrawal();
    test_reset_mid_wait();
    test_random();
`ifdef AXI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
